// File: rtl/subtrator_completo_pkg.sv
// Shared constants for the ripple-borrow full subtractor.
package subtrator_completo_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int MAX_WIDTH     = 64;

endpackage

// File: rtl/subtrator_bit.sv
// One-bit full subtractor cell: difference and borrow-out from a, b and borrow-in.
module subtrator_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic diff_s;

  assign diff_s = a ^ b;
  assign d      = diff_s ^ bin;
  // A borrow leaves this bit when b outweighs a, or when they tie and one arrives.
  assign bout   = (~a & b) | (~diff_s & bin);

endmodule

// File: rtl/subtrator_completo.sv
// WIDTH-bit ripple-borrow subtractor with live combinational outputs and a
// strobed, synchronously reset output register.
module subtrator_completo
  import subtrator_completo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             valid_q
);

  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             valid_r;

  assign borrow_s[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      subtrator_bit u_bit (
        .a    (a[i]),
        .b    (b[i]),
        .bin  (borrow_s[i]),
        .d    (diff_s[i]),
        .bout (borrow_s[i+1])
      );
    end
  endgenerate

  assign s    = diff_s;
  assign cout = borrow_s[WIDTH];

  // Output register: reset clears, strobe captures, otherwise the result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r     <= '0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (en) begin
      s_r     <= diff_s;
      cout_r  <= borrow_s[WIDTH];
      valid_r <= 1'b1;
    end else begin
      s_r     <= s_r;
      cout_r  <= cout_r;
      valid_r <= valid_r;
    end
  end

  assign s_q     = s_r;
  assign cout_q  = cout_r;
  assign valid_q = valid_r;

endmodule

// File: tb/tb_subtrator_completo.sv
// Scoreboard bench: stimulus pushes expected register contents per edge,
// a monitor pops and compares after each rising edge.
module tb_subtrator_completo;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, cin;
  logic [7:0] a, b, s, s_q;
  logic       cout, cout_q, valid_q;

  logic       a1, b1, cin1, s1, cout1, s1_q, cout1_q, valid1_q;
  logic       rst1 = 1'b1;
  logic       en1  = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q[$];
  exp_t held;

  subtrator_completo #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
    .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q), .valid_q(valid_q)
  );

  subtrator_completo #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .cin(cin1), .en(en1),
    .s(s1), .cout(cout1), .s_q(s1_q), .cout_q(cout1_q), .valid_q(valid1_q)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, cout in bit 8.
  function automatic logic [8:0] ref_sub(input int x, input int y, input int c);
    int d;
    d = x - y - c;
    ref_sub = {(x < y + c) ? 1'b1 : 1'b0, d[7:0]};
  endfunction

  task automatic step(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input logic te, input logic tr);
    logic [8:0] r;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; en = te; rst = tr;
    #1;
    r = ref_sub(int'(ta), int'(tb_v), int'(tc));
    check("comb_s", s, r[7:0]);
    check("comb_cout", cout, r[8]);
    if (tr) held = '{8'h00, 1'b0, 1'b0};
    else if (te === 1'b1) held = '{r[7:0], r[8], 1'b1};
    q.push_back(held);
  endtask

  // Monitor: one expected entry per edge that the stimulus announced.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("reg_s_q", s_q, e.s);
        check("reg_cout_q", cout_q, e.c);
        check("reg_valid_q", valid_q, e.v);
      end
    end
  end

  initial begin
    logic [1:0] tbl [8];
    logic [7:0] ra, rb;
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    held = '{8'h00, 1'b0, 1'b0};
    a = 8'h00; b = 8'h00; cin = 1'b0; en = 1'b0; rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      #1;
      check("w1_exhaustive", {s1, cout1}, tbl[i]);
    end

    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
    step(8'h05, 8'h03, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1);
    step(8'h3C, 8'h11, 1'b0, 1'b0, 1'b0);
    step(8'h9A, 8'h0F, 1'b1, 1'bx, 1'b1);
    step(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      step(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subtrator_completo.md
SUBTRATOR_COMPLETO -- requirements
Module: subtrator_completo

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 Port clk, input, 1: single clock; all registers update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port a, input, WIDTH: minuend.
REQ-005 Port b, input, WIDTH: subtrahend.
REQ-006 Port cin, input, 1: borrow-in, weight 2^0.
REQ-007 Port en, input, 1: capture strobe for the registered outputs.
REQ-008 Port s, output, WIDTH: combinational difference.
REQ-009 Port cout, output, 1: combinational borrow-out.
REQ-010 Port s_q, output, WIDTH: registered difference.
REQ-011 Port cout_q, output, 1: registered borrow-out.
REQ-012 Port valid_q, output, 1: high when s_q/cout_q hold a captured result.
REQ-013 One clock; reset is synchronous and active-high.

Function
REQ-014 s SHALL equal (a - b - cin) mod 2^WIDTH, with operands treated as unsigned and zero latency.
REQ-015 cout SHALL be 1 exactly when a < b + cin (unsigned compare, computed without overflow), else 0.
REQ-016 Per bit i, with bin0 = cin: s[i] = a[i] XOR b[i] XOR bin_i.
REQ-017 Per bit i: bout_i = (NOT a[i] AND b[i]) OR (NOT (a[i] XOR b[i]) AND bin_i).
REQ-018 Per bit i: bin_{i+1} = bout_i, and cout = bout_{WIDTH-1} (ripple borrow).
REQ-019 s and cout SHALL depend only on a, b and cin, never on clk, rst or en.
REQ-020 On a rising clk edge with rst=0 and en=1, s_q<=s, cout_q<=cout and valid_q<=1 (latency 1 cycle).
REQ-021 On a rising clk edge with rst=0 and en=0, s_q, cout_q and valid_q SHALL hold their values.
REQ-022 Boundary a=0, b=all-ones, cin=1: s = 0 and cout = 1.
REQ-023 Boundary a=b and cin=0: s = 0 and cout = 0.
REQ-024 An X or Z on en SHALL NOT corrupt s or cout.

Reset
REQ-025 On a rising clk edge with rst=1: s_q<=0, cout_q<=0, valid_q<=0.
REQ-026 rst SHALL take priority over en.
REQ-027 Combinational outputs s and cout SHALL stay live during reset.
REQ-028 Asserting reset mid-stream SHALL discard the held result; the first capture after reset deasserts SHALL occur on the next edge with en=1.

Structure
REQ-029 A shared package SHALL hold the WIDTH default and the local constant MAX_WIDTH=64.
REQ-030 One sub-module, subtrator_bit (a, b, bin -> d, bout), SHALL implement REQ-016/017.
REQ-031 The top SHALL instantiate subtrator_bit WIDTH times in a generate loop.
REQ-032 The top SHALL contain the output registers.
REQ-033 No latches and no combinational loops.

Verification
REQ-034 WIDTH=1 exhaustive, (a,b,cin) -> (s,cout): 000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.
REQ-035 WIDTH=8: a=0x00, b=0xFF, cin=1 -> s=0x00, cout=1.
REQ-036 WIDTH=8: a=0x80, b=0x01, cin=0 -> s=0x7F, cout=0.
REQ-037 WIDTH=8: a=0x05, b=0x03, cin=1, en=1, one clk edge -> s_q=0x01, cout_q=0, valid_q=1.
REQ-038 With s_q/cout_q/valid_q holding a result, rst=1 with en=1 for one edge -> s_q=0, cout_q=0, valid_q=0, while s still tracks inputs.
REQ-039 WIDTH=8: en=0 for 3 edges while a/b change -> s_q, cout_q and valid_q unchanged.
